// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one registered-operand ALU between two requesters
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [31:0] req0_imm,
  input  logic [2:0]  req0_ctrl,
  input  logic        req0_src,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  logic [31:0] req1_imm,
  input  logic [2:0]  req1_ctrl,
  input  logic        req1_src,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_regop2,
  output logic [31:0] alu_imm,
  output logic [2:0]  alu_ctrl,
  output logic        alu_src,
  input  logic [31:0] alu_result,
  input  logic        alu_eq,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_eq
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, gnt, hs;
  always_comb begin
    gnt = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    req0_ready = !rst && state == IDLE && req0_valid && !gnt;
    req1_ready = !rst && state == IDLE && req1_valid && gnt;
    hs = req0_ready || req1_ready;
    rsp_valid = !rst && state == RESP;
    state_nx = state == IDLE ? (hs ? EXEC : IDLE) :
               state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      alu_op1 <= '0;
      alu_regop2 <= '0;
      alu_imm <= '0;
      alu_ctrl <= '0;
      alu_src <= 1'b0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_eq <= 1'b0;
    end else begin
      state <= state_nx;
      if (hs) begin
        last_grant <= gnt;
        rsp_id <= gnt;
        alu_op1 <= gnt ? req1_op1 : req0_op1;
        alu_regop2 <= gnt ? req1_op2 : req0_op2;
        alu_imm <= gnt ? req1_imm : req0_imm;
        alu_ctrl <= gnt ? req1_ctrl : req0_ctrl;
        alu_src <= gnt ? req1_src : req0_src;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_eq <= alu_eq;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU attached
module tb_alu_arbiter;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_op1 = 0, req0_op2 = 0, req0_imm = 0, req1_op1 = 0, req1_op2 = 0, req1_imm = 0;
  logic [2:0] req0_ctrl = 0, req1_ctrl = 0;
  logic req0_src = 0, req1_src = 0;
  logic [31:0] alu_op1, alu_regop2, alu_imm, alu_result, rsp_result;
  logic [2:0] alu_ctrl;
  logic alu_src, alu_eq, rsp_valid, rsp_ready = 1, rsp_id, rsp_eq;

  typedef struct packed {logic id; logic [31:0] res; logic eq; logic [31:0] cyc;} rec_t;
  rec_t exp_q[$], got_q[$], e, g;
  logic gnt_q[$];
  logic [31:0] cyc = 0, rise_cyc = 0;
  int n_hs = 0, n_rise = 0, n_cmp = 0, n_bad = 0;
  logic rv_prev = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req0_imm(req0_imm), .req0_ctrl(req0_ctrl), .req0_src(req0_src),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req1_imm(req1_imm), .req1_ctrl(req1_ctrl), .req1_src(req1_src),
    .alu_op1(alu_op1), .alu_regop2(alu_regop2), .alu_imm(alu_imm), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
    .alu_result(alu_result), .alu_eq(alu_eq),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_eq(rsp_eq)
  );

  function automatic logic [32:0] alu_f(input logic [31:0] a, b2, i, input logic [2:0] c, input logic s);
    logic [31:0] b, r;
    b = s ? i : b2;
    r = c == 3'b000 ? a + b : c == 3'b001 ? a - b : c == 3'b010 ? a & b : c == 3'b011 ? a | b :
        c == 3'b100 ? a ^ b : c == 3'b101 ? a << b[4:0] : c == 3'b110 ? {31'd0, $signed(a) < $signed(b)} :
        {31'd0, a < b};
    return {a == b, r};
  endfunction

  assign {alu_eq, alu_result} = alu_f(alu_op1, alu_regop2, alu_imm, alu_ctrl, alu_src);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [32:0] m;
    if (rst) begin
      exp_q.delete();
      rv_prev = 0;
    end else begin
      if (req0_valid && req0_ready) begin
        m = alu_f(req0_op1, req0_op2, req0_imm, req0_ctrl, req0_src);
        exp_q.push_back({1'b0, m[31:0], m[32], cyc + 32'd2});
        gnt_q.push_back(1'b0);
        n_hs++;
      end
      if (req1_valid && req1_ready) begin
        m = alu_f(req1_op1, req1_op2, req1_imm, req1_ctrl, req1_src);
        exp_q.push_back({1'b1, m[31:0], m[32], cyc + 32'd2});
        gnt_q.push_back(1'b1);
        n_hs++;
      end
      if (rsp_valid && !rv_prev) begin
        rise_cyc = cyc;
        n_rise++;
      end
      if (rsp_valid && rsp_ready) got_q.push_back({rsp_id, rsp_result, rsp_eq, rise_cyc});
      rv_prev = rsp_valid;
    end
  end

  task automatic issue(input logic n, input logic [31:0] a, b, i, input logic [2:0] c, input logic s);
    int t = n_hs;
    if (n) begin
      {req1_op1, req1_op2, req1_imm, req1_ctrl, req1_src} = {a, b, i, c, s};
      req1_valid = 1;
    end else begin
      {req0_op1, req0_op2, req0_imm, req0_ctrl, req0_src} = {a, b, i, c, s};
      req0_valid = 1;
    end
    for (int k = 0; k < 20 && n_hs == t; k++) begin @(posedge clk); #1; end
    if (n) req1_valid = 0; else req0_valid = 0;
    if (n_hs == t) begin n_cmp++; n_bad++; $display("FAIL issue_timeout req%0d got no handshake in 20 cycles", n); end
  endtask

  task automatic wait_hs(input int target);
    for (int k = 0; k < 40 && n_hs < target; k++) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1; req0_valid = 1; req1_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
      n_bad++; $display("FAIL reset_outputs got ready0/ready1/rsp_valid=%b want 000", {req0_ready, req1_ready, rsp_valid});
    end
    n_cmp++;
    if ({alu_op1, alu_regop2, alu_imm, alu_ctrl, alu_src} !== '0) begin
      n_bad++; $display("FAIL reset_operands got op1=%h op2=%h imm=%h ctrl=%b src=%b want 0", alu_op1, alu_regop2, alu_imm, alu_ctrl, alu_src);
    end
    n_cmp++;
    if ({rsp_id, rsp_result, rsp_eq} !== '0) begin
      n_bad++; $display("FAIL reset_rsp got id=%b result=%h eq=%b want 0", rsp_id, rsp_result, rsp_eq);
    end
    rst = 0;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_bad++; $display("FAIL reset_first_tie got ready0/ready1=%b want 10", {req0_ready, req1_ready});
    end
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_tie;
    int t = n_hs, b = gnt_q.size();
    {req0_op1, req0_op2, req0_imm, req0_ctrl, req0_src} = {32'd1, 32'd2, 32'd0, 3'b000, 1'b0};
    {req1_op1, req1_op2, req1_imm, req1_ctrl, req1_src} = {32'd7, 32'd7, 32'd0, 3'b001, 1'b0};
    req0_valid = 1; req1_valid = 1;
    wait_hs(t + 1);
    req0_valid = 0;
    wait_hs(t + 2);
    req1_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (gnt_q.size() < b + 2 || {gnt_q[b], gnt_q[b + 1]} !== 2'b01) begin
      n_bad++; $display("FAIL tie_order got %0d grants want order 0,1", gnt_q.size() - b);
    end
    n_cmp++;
    if (got_q.size() !== 2) begin n_bad++; $display("FAIL tie_count got %0d responses want 2", got_q.size()); end
    while (got_q.size() && exp_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL tie_rsp got id=%b res=%h eq=%b cyc=%0d want id=%b res=%h eq=%b cyc=%0d", g.id, g.res, g.eq, g.cyc, e.id, e.res, e.eq, e.cyc); end
    end
  endtask

  task automatic test_alternation;
    int t = n_hs, b = gnt_q.size();
    logic [3:0] gv;
    {req0_op1, req0_op2, req0_imm, req0_ctrl, req0_src} = {32'd10, 32'd20, 32'd0, 3'b000, 1'b0};
    {req1_op1, req1_op2, req1_imm, req1_ctrl, req1_src} = {32'd50, 32'd8, 32'd0, 3'b001, 1'b0};
    req0_valid = 1; req1_valid = 1;
    wait_hs(t + 4);
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    gv = 'x;
    for (int k = 0; k < 4; k++) if (b + k < gnt_q.size()) gv[3 - k] = gnt_q[b + k];
    n_cmp++;
    if (gnt_q.size() !== b + 4 || gv !== 4'b0101) begin
      n_bad++; $display("FAIL alternation got %0d grants order=%b want 4 grants order=0101", gnt_q.size() - b, gv);
    end
    n_cmp++;
    if (got_q.size() !== 4) begin n_bad++; $display("FAIL alternation_count got %0d responses want 4", got_q.size()); end
    while (got_q.size() && exp_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL alternation_rsp got id=%b res=%h eq=%b cyc=%0d want id=%b res=%h eq=%b cyc=%0d", g.id, g.res, g.eq, g.cyc, e.id, e.res, e.eq, e.cyc); end
    end
  endtask

  task automatic test_single;
    issue(0, 32'd5, 32'd3, 32'd0, 3'b000, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() !== 1) begin n_bad++; $display("FAIL single_count got %0d responses want 1", got_q.size()); end
    n_cmp++;
    if (got_q.size() && got_q[0][65:33] !== {1'b0, 32'd8}) begin n_bad++; $display("FAIL single_fixed got res=%h want 8", got_q[0].res); end
    while (got_q.size() && exp_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL single_rsp got id=%b res=%h eq=%b cyc=%0d want id=%b res=%h eq=%b cyc=%0d", g.id, g.res, g.eq, g.cyc, e.id, e.res, e.eq, e.cyc); end
    end
  endtask

  task automatic test_imm;
    issue(1, 32'h0F, 32'hF00, 32'h3C, 3'b011, 1'b1);
    for (int k = 0; k < 10 && !rsp_valid; k++) begin @(posedge clk); #1; end
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_result} !== {2'b11, 32'h3F}) begin
      n_bad++; $display("FAIL imm_result got valid=%b id=%b res=%h want valid=1 id=1 res=0000003f", rsp_valid, rsp_id, rsp_result);
    end
    repeat (3) @(posedge clk);
    #1;
    while (got_q.size() && exp_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL imm_rsp got id=%b res=%h eq=%b cyc=%0d want id=%b res=%h eq=%b cyc=%0d", g.id, g.res, g.eq, g.cyc, e.id, e.res, e.eq, e.cyc); end
    end
  endtask

  task automatic test_ctrl;
    issue(0, 32'hA5A5_0F0F, 32'h0F0F_FFFF, 32'd0, 3'b100, 1'b0);
    issue(1, 32'hFFFF_FFFE, 32'd1, 32'd0, 3'b110, 1'b0);
    issue(0, 32'd3, 32'd9, 32'hFFFF_0000, 3'b111, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() !== 3) begin n_bad++; $display("FAIL ctrl_count got %0d responses want 3", got_q.size()); end
    while (got_q.size() && exp_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL ctrl_rsp got id=%b res=%h eq=%b cyc=%0d want id=%b res=%h eq=%b cyc=%0d", g.id, g.res, g.eq, g.cyc, e.id, e.res, e.eq, e.cyc); end
    end
  endtask

  task automatic test_drop;
    int t = n_hs;
    req1_valid = 1;
    #1;
    n_cmp++;
    if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL drop_offer got ready1=%b want 1", req1_ready); end
    req1_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (n_hs !== t || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL drop_forfeit got handshakes=%0d rsp_valid=%b want 0 and 0", n_hs - t, rsp_valid); end
    req0_valid = 1;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL drop_idle got ready0=%b want 1", req0_ready); end
    req0_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int r;
    logic [33:0] saved;
    rsp_ready = 0;
    r = n_rise;
    issue(0, 32'h1234, 32'h1234, 32'd0, 3'b010, 1'b0);
    for (int k = 0; k < 10 && !rsp_valid; k++) begin @(posedge clk); #1; end
    saved = {rsp_id, rsp_result, rsp_eq};
    req0_valid = 1; req1_valid = 1;
    repeat (5) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({rsp_valid, req0_ready, req1_ready, rsp_id, rsp_result, rsp_eq} !== {3'b100, saved}) begin
        n_bad++; $display("FAIL bp_hold got valid=%b rdy=%b%b id=%b res=%h eq=%b want valid=1 rdy=00 fields=%h", rsp_valid, req0_ready, req1_ready, rsp_id, rsp_result, rsp_eq, saved);
      end
    end
    req0_valid = 0; req1_valid = 0;
    rsp_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() !== 1 || n_rise - r !== 1) begin n_bad++; $display("FAIL bp_count got %0d responses %0d rises want 1 and 1", got_q.size(), n_rise - r); end
    while (got_q.size() && exp_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL bp_rsp got id=%b res=%h eq=%b cyc=%0d want id=%b res=%h eq=%b cyc=%0d", g.id, g.res, g.eq, g.cyc, e.id, e.res, e.eq, e.cyc); end
    end
  endtask

  task automatic test_reset_exec;
    int r = n_rise;
    issue(0, 32'd40, 32'd2, 32'd0, 3'b000, 1'b0);
    rst = 1;
    @(posedge clk); #1;
    n_cmp++;
    if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin n_bad++; $display("FAIL rstexec_outputs got %b want 000", {req0_ready, req1_ready, rsp_valid}); end
    rst = 0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (n_rise !== r || got_q.size() !== 0) begin n_bad++; $display("FAIL rstexec_discard got %0d rises %0d responses want 0 and 0", n_rise - r, got_q.size()); end
    req0_valid = 1; req1_valid = 1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL rstexec_last_grant got ready0/ready1=%b want 10", {req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_tie;
    test_alternation;
    test_single;
    test_imm;
    test_ctrl;
    test_drop;
    test_backpressure;
    test_reset_exec;
    n_cmp++;
    if (exp_q.size() !== 0 || got_q.size() !== 0) begin n_bad++; $display("FAIL leftover got exp=%0d got=%0d want 0 and 0", exp_q.size(), got_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
